// File: rtl/pipelined_subtractor.sv
// Four-stage pipelined subtractor: D = A - B - BI, one CHUNK-bit slice per stage,
// least significant first, with valid/ready flow control on both ends.
module pipelined_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             OV
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  diff_q   [STAGES];
  logic              borrow_q [STAGES];
  logic [WIDTH-1:0]  a_q      [STAGES];
  logic [WIDTH-1:0]  b_q      [STAGES];

  logic [STAGES-1:0] ready;
  logic              all_full;
  logic [WIDTH-1:0]  diff_d   [STAGES];
  logic              borrow_d [STAGES];
  logic [CHUNK:0]    sum;

  // A stage may load unless it and every stage after it are full while the consumer stalls.
  always_comb begin
    ready    = '0;
    all_full = 1'b1;
    for (int k = LAST; k >= 0; k--) begin
      all_full = all_full & valid_q[k];
      ready[k] = OutReady | ~all_full;
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      diff_d[k]   = '0;
      borrow_d[k] = 1'b0;
    end

    sum = {1'b0, A[CHUNK-1:0]} + {1'b0, ~B[CHUNK-1:0]} + {{CHUNK{1'b0}}, ~BI};
    diff_d[0][CHUNK-1:0] = sum[CHUNK-1:0];
    borrow_d[0]          = ~sum[CHUNK];

    for (int k = 1; k < STAGES; k++) begin
      sum = {1'b0, a_q[k-1][k*CHUNK +: CHUNK]}
          + {1'b0, ~b_q[k-1][k*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, ~borrow_q[k-1]};
      diff_d[k]                   = diff_q[k-1];
      diff_d[k][k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      borrow_d[k]                 = ~sum[CHUNK];
    end
  end

  // Operands travel with their partial result so later stages can resolve their own slice.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        diff_q[k]   <= '0;
        borrow_q[k] <= 1'b0;
        a_q[k]      <= '0;
        b_q[k]      <= '0;
      end
    end else begin
      if (ready[0]) begin
        valid_q[0]  <= InValid;
        diff_q[0]   <= diff_d[0];
        borrow_q[0] <= borrow_d[0];
        a_q[0]      <= A;
        b_q[0]      <= B;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k]  <= valid_q[k-1];
          diff_q[k]   <= diff_d[k];
          borrow_q[k] <= borrow_d[k];
          a_q[k]      <= a_q[k-1];
          b_q[k]      <= b_q[k-1];
        end
      end
    end
  end

  assign InReady  = ready[0];
  assign OutValid = valid_q[LAST];
  assign D        = diff_q[LAST];
  assign BO       = borrow_q[LAST];
  assign OV       = (a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1])
                  & (diff_q[LAST][WIDTH-1] ^ a_q[LAST][WIDTH-1]);

endmodule
